// File: rtl/coin_pkg.sv
// Shared definitions for the coin transfer sequencer: widths, FSM encoding, flag bits.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package coin_pkg;

   localparam int BAL_W_DEF = 8;
   localparam int ID_W_DEF  = 1;

   // FSM state encoding, 4-bit
   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_RD_SND = 4'd1;
   localparam logic [3:0] S_RD_RCV = 4'd2;
   localparam logic [3:0] S_CAPT   = 4'd3;
   localparam logic [3:0] S_CHECK  = 4'd4;
   localparam logic [3:0] S_WR_SND = 4'd5;
   localparam logic [3:0] S_WR_RCV = 4'd6;
   localparam logic [3:0] S_DONE   = 4'd7;

   // Result flag bit positions
   localparam int FLAG_INSUF = 0;
   localparam int FLAG_OVF   = 1;
   localparam int FLAG_W     = 2;

endpackage

// File: rtl/balance_check.sv
// Balance arithmetic for one transfer: debited/credited values, funds and carry checks.
// Latency: purely combinational.
// Backpressure: none.
module balance_check
   import coin_pkg::*;
#(
   parameter int BAL_W = BAL_W_DEF
) (
   input  logic [BAL_W-1:0] snd_bal,
   input  logic [BAL_W-1:0] rcv_bal,
   input  logic [BAL_W-1:0] amount,
   output logic [BAL_W-1:0] new_snd,
   output logic [BAL_W-1:0] new_rcv,
   output logic             insufficient,
   output logic             carry
);

   assign new_snd      = snd_bal - amount;
   // Receiver sum keeps its carry so the caller can choose to wrap or reject.
   assign {carry, new_rcv} = {1'b0, rcv_bal} + {1'b0, amount};
   assign insufficient = (snd_bal < amount);

endmodule

// File: rtl/transaction_sequencer.sv
// Sequences one coin transfer through the single-port balance RAM (read, check, write, report).
// Latency: finished 7 cycles after start on success, 5 when rejected or self transfer.
// Backpressure: completion is held until start_transaction drops. Optional macro TX_OVERFLOW_CHECK_EN.
module transaction_sequencer
   import coin_pkg::*;
#(
   parameter int BAL_W = BAL_W_DEF,
   parameter int ID_W  = ID_W_DEF
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             start_transaction,
   input  logic [BAL_W-1:0] amount,
   input  logic [ID_W-1:0]  sender_id,
   input  logic [ID_W-1:0]  receiver_id,
   input  logic [BAL_W-1:0] mem_rdata,
   output logic [ID_W-1:0]  mem_addr,
   output logic [BAL_W-1:0] mem_wdata,
   output logic             mem_we,
   output logic             busy,
   output logic             finished_transaction,
   output logic             insufficient_funds,
   output logic             tx_overflow
);

`ifdef TX_OVERFLOW_CHECK_EN
   localparam bit OVF_EN = 1'b1;
`else
   // Without the check the receiver sum wraps and the overflow flag can never be set.
   localparam bit OVF_EN = 1'b0;
`endif

   logic [3:0]        state_q, state_d;
   logic [BAL_W-1:0]  amt_q, snd_bal_q, rcv_bal_q;
   logic [ID_W-1:0]   snd_id_q, rcv_id_q;
   logic [FLAG_W-1:0] flags_q;

   logic [BAL_W-1:0]  new_snd, new_rcv;
   logic              insufficient, carry;
   logic              self_xfer;

   balance_check #(.BAL_W(BAL_W)) u_check (
      .snd_bal      (snd_bal_q),
      .rcv_bal      (rcv_bal_q),
      .amount       (amt_q),
      .new_snd      (new_snd),
      .new_rcv      (new_rcv),
      .insufficient (insufficient),
      .carry        (carry)
   );

   assign self_xfer = (snd_id_q == rcv_id_q);

   // State register
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // Next-state: fixed walk through the RAM accesses; start is only looked at in IDLE and DONE
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (start_transaction) state_d = S_RD_SND;
         S_RD_SND: state_d = S_RD_RCV;
         S_RD_RCV: state_d = S_CAPT;
         S_CAPT:   state_d = S_CHECK;
         S_CHECK: begin
            if (self_xfer)            state_d = S_DONE;
            else if (insufficient)    state_d = S_DONE;
            else if (OVF_EN && carry) state_d = S_DONE;
            else                      state_d = S_WR_SND;
         end
         S_WR_SND: state_d = S_WR_RCV;
         S_WR_RCV: state_d = S_DONE;
         S_DONE:   if (!start_transaction) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Request latching, balance capture (RAM data arrives one cycle after its address) and result flags
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         amt_q     <= '0;
         snd_id_q  <= '0;
         rcv_id_q  <= '0;
         snd_bal_q <= '0;
         rcv_bal_q <= '0;
         flags_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (start_transaction) begin
               amt_q    <= amount;
               snd_id_q <= sender_id;
               rcv_id_q <= receiver_id;
               flags_q  <= '0;
            end
            S_RD_RCV: snd_bal_q <= mem_rdata;
            S_CAPT:   rcv_bal_q <= mem_rdata;
            S_CHECK: if (!self_xfer) begin
               if (insufficient)         flags_q[FLAG_INSUF] <= 1'b1;
               else if (OVF_EN && carry) flags_q[FLAG_OVF]   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Outputs: RAM port muxing per state, status levels
   always_comb begin
      mem_addr             = '0;
      mem_wdata            = '0;
      mem_we               = 1'b0;
      busy                 = (state_q != S_IDLE);
      finished_transaction = 1'b0;
      case (state_q)
         S_RD_SND: mem_addr = snd_id_q;
         S_RD_RCV: mem_addr = rcv_id_q;
         S_WR_SND: begin
            mem_addr  = snd_id_q;
            mem_wdata = new_snd;
            mem_we    = 1'b1;
         end
         S_WR_RCV: begin
            mem_addr  = rcv_id_q;
            mem_wdata = new_rcv;
            mem_we    = 1'b1;
         end
         S_DONE:   finished_transaction = 1'b1;
         default: ;
      endcase
   end

   assign insufficient_funds = flags_q[FLAG_INSUF];
   assign tx_overflow        = flags_q[FLAG_OVF];

endmodule

// File: tb/tb_transaction_sequencer.sv
// Self-checking bench for transaction_sequencer: directed scenarios then randomized transfers.
// Latency: n/a.
// Backpressure: n/a.
module tb_transaction_sequencer;

`ifdef TX_OVERFLOW_CHECK_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       start_transaction = 1'b0;
   logic [7:0] amount = 8'd0;
   logic       sender_id = 1'b0;
   logic       receiver_id = 1'b0;
   logic [7:0] mem_rdata = 8'd0;
   logic       mem_addr;
   logic [7:0] mem_wdata;
   logic       mem_we;
   logic       busy;
   logic       finished_transaction;
   logic       insufficient_funds;
   logic       tx_overflow;

   transaction_sequencer #(.BAL_W(8), .ID_W(1)) dut (
      .clock                (clock),
      .resetn               (resetn),
      .start_transaction    (start_transaction),
      .amount               (amount),
      .sender_id            (sender_id),
      .receiver_id          (receiver_id),
      .mem_rdata            (mem_rdata),
      .mem_addr             (mem_addr),
      .mem_wdata            (mem_wdata),
      .mem_we               (mem_we),
      .busy                 (busy),
      .finished_transaction (finished_transaction),
      .insufficient_funds   (insufficient_funds),
      .tx_overflow          (tx_overflow)
   );

   always #5 clock = ~clock;

   // Balance RAM: registered read, write on the same edge
   logic [7:0] ram [0:1];
   always @(posedge clock) begin
      mem_rdata <= ram[mem_addr];
      if (mem_we) ram[mem_addr] = mem_wdata;
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_busy"},  32'(busy), 0);
      chk({tag, "_fin"},   32'(finished_transaction), 0);
      chk({tag, "_we"},    32'(mem_we), 0);
      chk({tag, "_addr"},  32'(mem_addr), 0);
      chk({tag, "_wdata"}, 32'(mem_wdata), 0);
   endtask

   task automatic preload(input logic [7:0] b0, input logic [7:0] b1);
      @(negedge clock);
      ram[0] = b0;
      ram[1] = b1;
   endtask

   // One transfer. drop_cyc>0 drops start after that cycle; otherwise start is held for
   // hold extra cycles after completion before being dropped.
   task automatic run_tx(input string tag, input logic [7:0] a, input logic s, input logic r,
                         input int drop_cyc, input int hold);
      logic [7:0] exp_ram [0:1];
      bit   exp_ins, exp_ovf, exp_we, we_seen, fin;
      int   exp_cyc, cyc;
      exp_ram[0] = ram[0];
      exp_ram[1] = ram[1];
      exp_ins = 0; exp_ovf = 0; exp_we = 0;
      if (s == r) exp_cyc = 5;
      else if (ram[s] < a) begin exp_ins = 1; exp_cyc = 5; end
      else if (OVF_EN && (int'(ram[r]) + int'(a) > 255)) begin exp_ovf = 1; exp_cyc = 5; end
      else begin
         exp_ram[s] = ram[s] - a;
         exp_ram[r] = 8'((int'(ram[r]) + int'(a)) % 256);
         exp_we = 1;
         exp_cyc = 7;
      end

      @(negedge clock);
      start_transaction = 1'b1;
      amount = a;
      sender_id = s;
      receiver_id = r;
      cyc = 0; we_seen = 0; fin = 0;
      while (!fin && cyc < 30) begin
         @(posedge clock); #1;
         cyc++;
         if (cyc == 1) begin
            chk({tag, "_busy"},      32'(busy), 1);
            chk({tag, "_rd_addr"},   32'(mem_addr), 32'(s));
            chk({tag, "_ins_clear"}, 32'(insufficient_funds), 0);
            chk({tag, "_ovf_clear"}, 32'(tx_overflow), 0);
         end
         if (cyc == 2) begin
            // later input changes must not affect the running transfer
            amount = ~a;
            sender_id = ~s;
            receiver_id = s;
         end
         if (mem_we) we_seen = 1;
         if (cyc == drop_cyc) start_transaction = 1'b0;
         fin = finished_transaction;
      end
      chk({tag, "_fin_cycle"}, 32'(cyc), 32'(exp_cyc));
      chk({tag, "_we_seen"},   32'(we_seen), 32'(exp_we));
      chk({tag, "_ins"},       32'(insufficient_funds), 32'(exp_ins));
      chk({tag, "_ovf"},       32'(tx_overflow), 32'(exp_ovf));
      if (drop_cyc <= 0) begin
         for (int h = 0; h < hold; h++) begin
            @(posedge clock); #1;
            chk({tag, "_fin_hold"}, 32'(finished_transaction), 1);
         end
         start_transaction = 1'b0;
      end
      @(posedge clock); #1;
      chk({tag, "_fin_drop"}, 32'(finished_transaction), 0);
      chk({tag, "_idle"},     32'(busy), 0);
      chk({tag, "_ram0"},     32'(ram[0]), 32'(exp_ram[0]));
      chk({tag, "_ram1"},     32'(ram[1]), 32'(exp_ram[1]));
      chk({tag, "_ins_held"}, 32'(insufficient_funds), 32'(exp_ins));
   endtask

   initial begin
      ram[0] = 8'd0;
      ram[1] = 8'd0;
      #2;
      chk_idle_outputs("reset");
      chk("reset_ins", 32'(insufficient_funds), 0);
      chk("reset_ovf", 32'(tx_overflow), 0);
      @(negedge clock);
      resetn = 1'b1;

      // basic transfer
      preload(8'd50, 8'd20);
      run_tx("basic", 8'd30, 1'b0, 1'b1, 0, 2);
      chk("basic_ram0_val", 32'(ram[0]), 20);
      chk("basic_ram1_val", 32'(ram[1]), 50);

      // insufficient funds, one short
      preload(8'd10, 8'd20);
      run_tx("insuf", 8'd11, 1'b0, 1'b1, 0, 0);
      chk_idle_outputs("insuf_after");

      // exact balance is enough
      preload(8'd11, 8'd5);
      run_tx("exact", 8'd11, 1'b0, 1'b1, 0, 0);

      // receiver overflow
      preload(8'd100, 8'd250);
      run_tx("ovf", 8'd10, 1'b0, 1'b1, 0, 0);
      if (OVF_EN) chk("ovf_ram1_val", 32'(ram[1]), 250);
      else        chk("ovf_ram1_val", 32'(ram[1]), 4);

      // self transfer
      preload(8'd7, 8'd9);
      run_tx("self", 8'd3, 1'b1, 1'b1, 0, 0);

      // zero amount
      preload(8'd0, 8'd200);
      run_tx("zero", 8'd0, 1'b1, 1'b0, 0, 0);

      // start held long, then dropped early in a later transfer
      preload(8'd90, 8'd1);
      run_tx("hold20", 8'd40, 1'b0, 1'b1, 0, 20);
      run_tx("drop2", 8'd5, 1'b1, 1'b0, 2, 0);

      // reset while the sender write is being presented
      preload(8'd80, 8'd30);
      @(negedge clock);
      start_transaction = 1'b1;
      amount = 8'd20;
      sender_id = 1'b0;
      receiver_id = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clock); #1;
      end
      chk("wrsnd_we",    32'(mem_we), 1);
      chk("wrsnd_addr",  32'(mem_addr), 0);
      chk("wrsnd_wdata", 32'(mem_wdata), 60);
      resetn = 1'b0;
      #1;
      chk_idle_outputs("midreset");
      start_transaction = 1'b0;
      @(negedge clock);
      resetn = 1'b1;
      @(posedge clock); #1;
      chk("midreset_ram1", 32'(ram[1]), 30);
      run_tx("post_reset", 8'd20, 1'b0, 1'b1, 0, 1);

      // randomized transfers
      for (int i = 0; i < 40; i++) begin
         logic [7:0] b0, b1, a;
         int d;
         b0 = 8'($urandom_range(0, 255));
         b1 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(230, 255)) : 8'($urandom_range(0, 255));
         a  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 255));
         d  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 4)) : 0;
         preload(b0, b1);
         run_tx("rand", a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), d,
                int'($urandom_range(0, 3)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
